// File: rtl/bp_io_cmd_arbiter.sv
// rtl/bp_io_cmd_arbiter.sv - shares one I/O command channel among requesters and routes in-order responses back
//
// Purpose:
//   Locked round-robin selection of one of num_req_p command sources onto a
//   single downstream I/O command port. A shared outstanding-credit counter
//   caps commands in flight. The requester ID of every issued command is
//   queued in an in-order ID FIFO. The FIFO head steers each returning
//   response to the requester that issued the matching command.
//
// Ports:
//   clk_i, reset_i            clock, asynchronous active-high reset
//   req_cmd_i/_v_i            per-requester packed commands and valids (slice i = requester i)
//   req_cmd_yumi_o            one-hot accept back to the granted requester
//   io_cmd_o/_v_o/_yumi_i     downstream command port
//   io_resp_i/_v_i/_ready_o   downstream response port
//   req_resp_o                response data, broadcast to all requesters
//   req_resp_v_o              one-hot response valid
//   req_resp_ready_i          per-requester response ready
//   outstanding_o             commands currently in flight
//   idle_o                    nothing in flight and no requester valid
//   error_o                   sticky: a response arrived with nothing outstanding

module bp_io_cmd_arbiter #(
    parameter int num_req_p         = 2,
    parameter int cmd_width_p       = 128,
    parameter int resp_width_p      = 64,
    parameter int max_outstanding_p = 16,
    localparam int id_width_lp      = (num_req_p > 1) ? $clog2(num_req_p) : 1,
    localparam int count_width_lp   = $clog2(max_outstanding_p + 1)
) (
    input  logic                             clk_i,
    input  logic                             reset_i,

    input  logic [num_req_p*cmd_width_p-1:0] req_cmd_i,
    input  logic [num_req_p-1:0]             req_cmd_v_i,
    output logic [num_req_p-1:0]             req_cmd_yumi_o,

    output logic [cmd_width_p-1:0]           io_cmd_o,
    output logic                             io_cmd_v_o,
    input  logic                             io_cmd_yumi_i,

    input  logic [resp_width_p-1:0]          io_resp_i,
    input  logic                             io_resp_v_i,
    output logic                             io_resp_ready_o,

    output logic [resp_width_p-1:0]          req_resp_o,
    output logic [num_req_p-1:0]             req_resp_v_o,
    input  logic [num_req_p-1:0]             req_resp_ready_i,

    output logic [count_width_lp-1:0]        outstanding_o,
    output logic                             idle_o,
    output logic                             error_o
);

    localparam int ptr_width_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [id_width_lp-1:0]    last_q,  last_d;
    logic                      lock_q,  lock_d;
    logic [id_width_lp-1:0]    lock_id_q, lock_id_d;
    logic [count_width_lp-1:0] count_q, count_d;
    logic [ptr_width_lp-1:0]   wptr_q,  wptr_d;
    logic [ptr_width_lp-1:0]   rptr_q,  rptr_d;
    logic                      err_q,   err_d;

    // ID FIFO storage; validity is tracked by the pointers and count only.
    logic [id_width_lp-1:0]    id_mem_q [max_outstanding_p];

    // ------------------------------------------------------------------
    // Issue path
    // ------------------------------------------------------------------
    logic                   full;
    logic                   fifo_empty;
    logic [id_width_lp-1:0] rr_sel;
    logic                   rr_found;
    int                     rr_idx;
    logic [id_width_lp-1:0] sel;
    logic                   push;
    logic                   pop;
    logic [id_width_lp-1:0] head;

    // The FIFO and the count move together, so the count doubles as occupancy.
    assign full       = (count_q == count_width_lp'(max_outstanding_p));
    assign fifo_empty = (count_q == '0);

    // Round-robin search starting just after the last grant, wrapping.
    always_comb begin
        rr_sel   = last_q;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int k = 1; k <= num_req_p; k++) begin
            rr_idx = (int'(last_q) + k) % num_req_p;
            if (!rr_found && req_cmd_v_i[rr_idx]) begin
                rr_sel   = id_width_lp'(rr_idx);
                rr_found = 1'b1;
            end
        end
    end

    // A presented-but-unaccepted command pins the selection so a newly valid
    // higher-priority requester cannot pull the command out from under the
    // downstream port.
    assign sel = lock_q ? lock_id_q : rr_sel;

    // Gating with reset_i keeps the valid low while reset is held even though
    // req_cmd_v_i is an unregistered input.
    assign io_cmd_v_o = ~reset_i & ~full & req_cmd_v_i[sel];
    assign io_cmd_o   = req_cmd_i[sel*cmd_width_p +: cmd_width_p];
    assign push       = io_cmd_v_o & io_cmd_yumi_i;

    always_comb begin
        req_cmd_yumi_o = '0;
        if (push) begin
            req_cmd_yumi_o[sel] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------
    assign head            = id_mem_q[rptr_q];
    assign req_resp_o      = io_resp_i;
    assign io_resp_ready_o = ~fifo_empty & req_resp_ready_i[head];
    assign pop             = io_resp_v_i & io_resp_ready_o;

    always_comb begin
        req_resp_v_o = '0;
        if (io_resp_v_i && !fifo_empty) begin
            req_resp_v_o[head] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        last_d    = last_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        count_d   = count_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        err_d     = err_q;

        if (push) begin
            last_d = sel;
            lock_d = 1'b0;
        end else if (io_cmd_v_o) begin
            lock_d    = 1'b1;
            lock_id_d = sel;
        end

        if (push) begin
            wptr_d = (wptr_q == ptr_width_lp'(max_outstanding_p - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = (rptr_q == ptr_width_lp'(max_outstanding_p - 1)) ? '0 : rptr_q + 1'b1;
        end

        // Push and pop together leave the count unchanged.
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        if (io_resp_v_i && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_q    <= id_width_lp'(num_req_p - 1);
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            count_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            last_q    <= last_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            count_q   <= count_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem_q[wptr_q] <= sel;
        end
    end

    // ------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------
    assign outstanding_o = count_q;
    assign idle_o        = fifo_empty & ~(|req_cmd_v_i);
    assign error_o       = err_q;

endmodule

// File: tb/tb_bp_io_cmd_arbiter.sv
// tb/tb_bp_io_cmd_arbiter.sv - directed self-checking bench for bp_io_cmd_arbiter

module tb_bp_io_cmd_arbiter;

    localparam int NREQ = 2;
    localparam int CW   = 16;
    localparam int RW   = 8;
    localparam int MAXO = 4;
    localparam int CNTW = $clog2(MAXO + 1);

    logic                 clk;
    logic                 rst;
    logic [NREQ*CW-1:0]   req_cmd;
    logic [NREQ-1:0]      req_cmd_v;
    logic [NREQ-1:0]      req_cmd_yumi;
    logic [CW-1:0]        io_cmd;
    logic                 io_cmd_v;
    logic                 io_cmd_yumi;
    logic [RW-1:0]        io_resp;
    logic                 io_resp_v;
    logic                 io_resp_ready;
    logic [RW-1:0]        req_resp;
    logic [NREQ-1:0]      req_resp_v;
    logic [NREQ-1:0]      req_resp_ready;
    logic [CNTW-1:0]      outstanding;
    logic                 idle;
    logic                 error;

    int n_total = 0;
    int n_pass  = 0;

    bp_io_cmd_arbiter #(
        .num_req_p(NREQ),
        .cmd_width_p(CW),
        .resp_width_p(RW),
        .max_outstanding_p(MAXO)
    ) dut (
        .clk_i(clk),
        .reset_i(rst),
        .req_cmd_i(req_cmd),
        .req_cmd_v_i(req_cmd_v),
        .req_cmd_yumi_o(req_cmd_yumi),
        .io_cmd_o(io_cmd),
        .io_cmd_v_o(io_cmd_v),
        .io_cmd_yumi_i(io_cmd_yumi),
        .io_resp_i(io_resp),
        .io_resp_v_i(io_resp_v),
        .io_resp_ready_o(io_resp_ready),
        .req_resp_o(req_resp),
        .req_resp_v_o(req_resp_v),
        .req_resp_ready_i(req_resp_ready),
        .outstanding_o(outstanding),
        .idle_o(idle),
        .error_o(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [CW-1:0] CMD0 = 16'hA000;
    localparam logic [CW-1:0] CMD1 = 16'hB001;

    initial begin
        rst            = 1'b1;
        req_cmd        = {CMD1, CMD0};
        req_cmd_v      = '0;
        io_cmd_yumi    = 1'b0;
        io_resp        = '0;
        io_resp_v      = 1'b0;
        req_resp_ready = '0;

        // Reset values
        #2;
        chk("rst_cmd_v",   io_cmd_v,      0);
        chk("rst_yumi",    req_cmd_yumi,  0);
        chk("rst_resp_v",  req_resp_v,    0);
        chk("rst_resp_rdy",io_resp_ready, 0);
        chk("rst_outst",   outstanding,   0);
        chk("rst_err",     error,         0);
        chk("rst_idle",    idle,          1);
        tick();
        rst = 1'b0;
        tick();

        // Single requester: four back-to-back issues fill the credit.
        req_cmd_v   = 2'b01;
        io_cmd_yumi = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("single_v",    io_cmd_v,     1);
            chk("single_cmd",  io_cmd,       CMD0);
            chk("single_yumi", req_cmd_yumi, 2'b01);
            tick();
        end
        #1;
        chk("full_v",     io_cmd_v,     0);
        chk("full_yumi",  req_cmd_yumi, 0);
        chk("full_outst", outstanding,  4);

        // Response handshake while full: issue still blocked this cycle.
        io_resp        = 8'h55;
        io_resp_v      = 1'b1;
        req_resp_ready = 2'b11;
        #1;
        chk("sim_resp_v",   req_resp_v,    2'b01);
        chk("sim_resp_rdy", io_resp_ready, 1);
        chk("sim_resp_dat", req_resp,      8'h55);
        chk("sim_cmd_v",    io_cmd_v,      0);
        tick();
        io_resp_v = 1'b0;
        #1;
        chk("after_pop_outst", outstanding, 3);
        chk("after_pop_v",     io_cmd_v,    1);
        tick();
        #1;
        chk("refill_outst", outstanding, 4);

        // Drain four responses, all owned by requester 0.
        req_cmd_v   = '0;
        io_cmd_yumi = 1'b0;
        io_resp_v   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_resp_v", req_resp_v, 2'b01);
            tick();
        end
        io_resp_v = 1'b0;
        #1;
        chk("drain_outst", outstanding, 0);
        chk("drain_idle",  idle,        1);
        chk("drain_err",   error,       0);

        // Round robin from a fresh reset: 0,1,0,1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        req_cmd_v   = 2'b11;
        io_cmd_yumi = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_yumi", req_cmd_yumi, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_cmd",  io_cmd,       (i % 2 == 0) ? CMD0 : CMD1);
            tick();
        end
        req_cmd_v   = '0;
        io_cmd_yumi = 1'b0;
        #1;
        chk("rr_outst", outstanding, 4);
        io_resp_v = 1'b1;
        for (int i = 0; i < 4; i++) begin
            io_resp = 8'(8'h10 + i);
            #1;
            chk("rr_route", req_resp_v, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_data",  req_resp,   8'(8'h10 + i));
            tick();
        end
        io_resp_v = 1'b0;
        #1;
        chk("rr_drain_outst", outstanding, 0);

        // Lock: requester 1 presented, held while requester 0 appears.
        req_cmd_v   = 2'b10;
        io_cmd_yumi = 1'b0;
        #1;
        chk("lock_c1_cmd",  io_cmd,       CMD1);
        chk("lock_c1_yumi", req_cmd_yumi, 0);
        tick();
        req_cmd_v = 2'b11;
        #1;
        chk("lock_c2_cmd", io_cmd, CMD1);
        tick();
        #1;
        chk("lock_c3_cmd", io_cmd, CMD1);
        io_cmd_yumi = 1'b1;
        #1;
        chk("lock_yumi", req_cmd_yumi, 2'b10);
        tick();
        req_cmd_v   = '0;
        io_cmd_yumi = 1'b0;
        #1;
        chk("lock_outst", outstanding, 1);

        // Backpressured response: head is requester 1, only requester 0 ready.
        io_resp        = 8'h77;
        io_resp_v      = 1'b1;
        req_resp_ready = 2'b01;
        #1;
        chk("bp_rdy",    io_resp_ready, 0);
        chk("bp_resp_v", req_resp_v,    2'b10);
        tick();
        #1;
        chk("bp_outst_held", outstanding, 1);
        req_resp_ready = 2'b11;
        #1;
        chk("bp_rdy_rise", io_resp_ready, 1);
        tick();
        io_resp_v = 1'b0;
        #1;
        chk("bp_outst_done", outstanding, 0);

        // Response with nothing outstanding sets a sticky error.
        io_resp_v = 1'b1;
        #1;
        chk("err_rdy",    io_resp_ready, 0);
        chk("err_resp_v", req_resp_v,    0);
        tick();
        io_resp_v = 1'b0;
        #1;
        chk("err_set", error, 1);
        tick();
        chk("err_sticky", error, 1);

        // Reset mid-operation with three in flight drops outputs immediately.
        req_cmd_v   = 2'b01;
        io_cmd_yumi = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        io_cmd_yumi = 1'b0;
        io_resp_v   = 1'b1;
        #1;
        chk("pre_rst_outst",  outstanding,   3);
        chk("pre_rst_cmd_v",  io_cmd_v,      1);
        chk("pre_rst_resp_v", req_resp_v,    2'b01);
        rst = 1'b1;
        #1;
        chk("arst_cmd_v",   io_cmd_v,      0);
        chk("arst_yumi",    req_cmd_yumi,  0);
        chk("arst_resp_v",  req_resp_v,    0);
        chk("arst_rdy",     io_resp_ready, 0);
        chk("arst_outst",   outstanding,   0);
        chk("arst_err",     error,         0);
        chk("arst_idle_busy", idle,        0);
        req_cmd_v = '0;
        io_resp_v = 1'b0;
        #1;
        chk("arst_idle", idle, 1);
        tick();
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bp_io_cmd_arbiter.md
# bp_io_cmd_arbiter

Shares one uncached I/O command channel between `num_req_p` requesters, such as the NBF stream loader and a host debug port. Commands are selected with locked round-robin arbitration. A single outstanding-credit limit covers all requesters. Responses return in order and are routed back to the requester that issued the matching command, using an in-order ID FIFO. The block sits between the requesters and the memory-side I/O command/response port.

## Interface
- `num_req_p`, 2, number of requesters; must be ≥2.
- `cmd_width_p`, 128, packed I/O command width; the block does not inspect it.
- `resp_width_p`, 64, packed I/O response width; the block does not inspect it.
- `max_outstanding_p`, 16, maximum number of commands issued without a response; also the ID FIFO depth.
- `id_width_lp`, local, `BSG_SAFE_CLOG2(num_req_p)`.
- `count_width_lp`, local, `BSG_WIDTH(max_outstanding_p)`.

Ports:
- `clk_i`  in  1  the single clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `req_cmd_i`  in  `num_req_p*cmd_width_p`  per-requester command; requester i occupies slice i.
- `req_cmd_v_i`  in  `num_req_p`  per-requester command valid; once raised, must be held until yumi.
- `req_cmd_yumi_o`  out  `num_req_p`  one-hot accept; at most one bit high per cycle.
- `io_cmd_o`  out  `cmd_width_p`  selected command.
- `io_cmd_v_o`  out  1  command valid.
- `io_cmd_yumi_i`  in  1  downstream accept; legal only when `io_cmd_v_o` is high.
- `io_resp_i`  in  `resp_width_p`  response data.
- `io_resp_v_i`  in  1  response valid.
- `io_resp_ready_o`  out  1  response accept.
- `req_resp_o`  out  `resp_width_p`  response data, broadcast to all requesters.
- `req_resp_v_o`  out  `num_req_p`  one-hot response valid.
- `req_resp_ready_i`  in  `num_req_p`  per-requester response ready.
- `outstanding_o`  out  `count_width_lp`  number of commands currently in flight.
- `idle_o`  out  1  high when `outstanding_o==0` and no `req_cmd_v_i` bit is set.
- `error_o`  out  1  sticky flag: a response arrived with nothing outstanding.

## Operation
State:
- `last_r` (id), the last-granted requester.
- `lock_r` / `lock_id_r`, the held selection.
- `count_r`, the outstanding count.
- ID FIFO (depth `max_outstanding_p`).
- `err_r`.

Issue path:
- `full` = (`count_r == max_outstanding_p`).
- When unlocked, `sel` is the first i with `req_cmd_v_i[i]`, searching from `last_r+1` modulo `num_req_p` and wrapping.
- When locked, `sel` = `lock_id_r`.
- `io_cmd_v_o` = ~`full` & `req_cmd_v_i[sel]`.
- `io_cmd_o` = `req_cmd_i[sel]`.
- If `io_cmd_v_o` is high and `io_cmd_yumi_i` is low, then `lock_r` is set and `lock_id_r` is loaded with `sel`. A newly valid higher-priority requester cannot steal the grant.
- On `io_cmd_yumi_i`:
  - `req_cmd_yumi_o[sel]` = 1 in the same cycle.
  - `sel` is pushed to the ID FIFO.
  - `last_r` ← `sel`.
  - `lock_r` is cleared.
  - `count_r` is incremented.
- `full` forces `io_cmd_v_o` low. A lock that is already held stays held while full.

Response path:
- `head` = ID FIFO head.
- `req_resp_o` = `io_resp_i`.
- `req_resp_v_o[head]` = `io_resp_v_i` & FIFO non-empty; all other bits are 0.
- `io_resp_ready_o` = FIFO non-empty & `req_resp_ready_i[head]`.
- On `io_resp_v_i` & `io_resp_ready_o`: pop the FIFO and decrement `count_r`.
- If `io_resp_v_i` is high while the FIFO is empty:
  - `io_resp_ready_o` is 0.
  - `err_r` is set and holds until reset.

Boundary cases:
- Push and pop in the same cycle: `count_r` is unchanged and the FIFO contents stay consistent.
- `full` is evaluated on the registered count. A same-cycle pop does not unblock issue until the next cycle.
- A command pushed this cycle cannot be the head for a same-cycle response; there is no bypass.
- Count wrap: `count_r` never exceeds `max_outstanding_p` and never goes below 0.

Reset:
- Asynchronous reset clears `count_r`, the FIFO pointers, `lock_r` and `err_r`.
- `last_r` resets to `num_req_p-1`, so requester 0 has first priority.
- Reset in the middle of operation discards all in-flight IDs. The downstream side must be reset in the same window.

## Timing
- Output values during and after reset:
  - `io_cmd_v_o` = 0.
  - `req_cmd_yumi_o` = 0.
  - `req_resp_v_o` = 0.
  - `io_resp_ready_o` = 0.
  - `outstanding_o` = 0.
  - `error_o` = 0.
  - `idle_o` = 1 when no requester is valid.
- Command path has zero latency: `req_cmd_v_i` → `io_cmd_v_o` and `io_cmd_yumi_i` → `req_cmd_yumi_o` are combinational.
- Response path is combinational: `io_resp_v_i` → `req_resp_v_o` and `req_resp_ready_i` → `io_resp_ready_o`.
- There is no combinational path from `io_resp_*` to the issue path.
- `outstanding_o` and `error_o` are registered and update one cycle after the handshake.
- Throughput: one command and one response per cycle.

## Test plan
- **Single requester:** `num_req_p`=2, `max_outstanding_p`=4. Only requester 0 is valid, with `io_cmd_yumi_i` held at 1.
  - Required: 4 issues on consecutive cycles.
  - Then `io_cmd_v_o`=0 and `outstanding_o`=4.
  - One response handshake brings `outstanding_o` to 3, and issue resumes on the next cycle.
- **Round robin:** both requesters continuously valid, yumi held at 1.
  - Required: grants in the order 0,1,0,1.
  - Responses R0..R3 route to `req_resp_v_o` = 01, 10, 01, 10.
- **Lock:** requester 1 is valid and yumi is held at 0 for 3 cycles; requester 0 rises in cycle 2.
  - Required: `io_cmd_o` stays on requester 1's command.
  - The first yumi asserts `req_cmd_yumi_o`=10.
- **Backpressured response:** head ID is 1 and `req_resp_ready_i`=01.
  - Required: `io_resp_ready_o`=0 and the FIFO is unchanged.
  - Raising `req_resp_ready_i[1]` completes the response.
- **Simultaneous events:** `outstanding_o`=4 with a response handshake and a valid request in the same cycle.
  - Required: no issue that cycle; issue the next cycle, after which `outstanding_o` returns to 4.
- **Error and reset:**
  - A response on an empty FIFO → `error_o`=1 and stays sticky.
  - Asserting reset with `outstanding_o`=3 → all outputs drop to their reset values asynchronously, before the next clock edge.
